// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic bus bundle for the 16-bit Zet bus (word address [20:1]).
// The "master" modport is the side that issues cycles; the "slave" modport
// is the side that answers them. dat_w carries write data towards the slave,
// dat_r carries read data back towards the master.
interface wb_arbiter_2m_if;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic [20:1] adr;
    logic [1:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport master (
        output dat_w, adr, sel, we, cyc, stb,
        input  dat_r, ack
    );

    modport slave (
        input  dat_w, adr, sel, we, cyc, stb,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter for the Zet bus.
// Shares one downstream master port between m0 (CPU) and m1 (DMA / video
// fetch). A master keeps the bus for as long as it holds cyc, ties from idle
// are broken round-robin, and a watchdog forces an error acknowledge when the
// slave stalls a strobe for TIMEOUT cycles so a hung or unmapped slave can
// never lock up either master. TIMEOUT = 0 turns the watchdog off.
module wb_arbiter_2m #(
    parameter int unsigned     TO_W    = 8,
    parameter logic [TO_W-1:0] TIMEOUT = 8'd255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_arbiter_2m_if.slave  m0,
    wb_arbiter_2m_if.slave  m1,
    wb_arbiter_2m_if.master s,
    output logic [1:0]      gnt_o,
    output logic            to_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic WD_EN = (TIMEOUT != '0);

    state_t          state_q;
    state_t          state_d;
    logic            last_q;
    logic            last_d;
    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic            own_cyc;
    logic            own_stb;

    // Select the cyc/stb of whichever master currently owns the bus.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            OWN0: begin
                own_cyc = m0.cyc;
                own_stb = m0.stb;
            end
            OWN1: begin
                own_cyc = m1.cyc;
                own_stb = m1.stb;
            end
            default: begin
                own_cyc = 1'b0;
                own_stb = 1'b0;
            end
        endcase
    end

    // A real slave ack in the same cycle always beats the watchdog.
    assign to_err_o = WD_EN && (cnt_q == TIMEOUT) && own_cyc && own_stb && !s.ack;

    // Next owner: hold while the owner keeps cyc, hand straight over to a
    // waiting master when it lets go, and alternate on ties from idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0.cyc) begin
                    state_d = OWN0;
                end else if (m1.cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0.cyc) begin
                    state_d = m1.cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1.cyc) begin
                    state_d = m0.cyc ? OWN0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Remember who was granted most recently so the next tie goes the other way.
    always_comb begin
        last_d = last_q;
        if (state_d == OWN0 && state_q != OWN0) begin
            last_d = 1'b0;
        end else if (state_d == OWN1 && state_q != OWN1) begin
            last_d = 1'b1;
        end
    end

    // Count consecutive stalled strobe cycles of the current owner.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || !own_cyc || !own_stb || s.ack || to_err_o) begin
            cnt_d = '0;
        end else if (cnt_q != TIMEOUT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Route the owner's request downstream and the slave's response back to it.
    always_comb begin
        gnt_o    = 2'b00;
        s.dat_w  = 16'h0000;
        s.adr    = 20'h00000;
        s.sel    = 2'b00;
        s.we     = 1'b0;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        m0.ack   = 1'b0;
        m0.dat_r = 16'h0000;
        m1.ack   = 1'b0;
        m1.dat_r = 16'h0000;
        case (state_q)
            OWN0: begin
                gnt_o    = 2'b01;
                s.dat_w  = m0.dat_w;
                s.adr    = m0.adr;
                s.sel    = m0.sel;
                s.we     = m0.we;
                s.cyc    = m0.cyc;
                s.stb    = m0.cyc && m0.stb && !to_err_o;
                m0.ack   = (s.ack || to_err_o) && m0.cyc && m0.stb;
                m0.dat_r = to_err_o ? 16'hFFFF : s.dat_r;
            end
            OWN1: begin
                gnt_o    = 2'b10;
                s.dat_w  = m1.dat_w;
                s.adr    = m1.adr;
                s.sel    = m1.sel;
                s.we     = m1.we;
                s.cyc    = m1.cyc;
                s.stb    = m1.cyc && m1.stb && !to_err_o;
                m1.ack   = (s.ack || to_err_o) && m1.cyc && m1.stb;
                m1.dat_r = to_err_o ? 16'hFFFF : s.dat_r;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

    // Grant, round-robin and watchdog state; reset abandons any open cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // The bus is never granted to both masters at once.
    a_gnt_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) $onehot0(gnt_o));

    // At most one master is acknowledged in any cycle.
    a_ack_excl: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) !(m0.ack && m1.ack));

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m.
// Two arbiters are exercised: dut_a with a 4-cycle watchdog for arbitration
// and timeout scenarios, dut_b with the watchdog disabled for a very slow
// slave. A bench-side model of grant ownership and stall time predicts every
// output each cycle; directed literal checks pin the model to known answers.
module tb_wb_arbiter_2m;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [1:0]  sel;
        logic [19:0] adr;
        logic [15:0] dat;
    } m_in_t;

    typedef struct {
        int owner;
        int last;
        int waited;
    } model_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_arbiter_2m_if bus_a0 ();
    wb_arbiter_2m_if bus_a1 ();
    wb_arbiter_2m_if bus_as ();
    wb_arbiter_2m_if bus_b0 ();
    wb_arbiter_2m_if bus_b1 ();
    wb_arbiter_2m_if bus_bs ();

    logic [1:0] gnt_a;
    logic       terr_a;
    logic [1:0] gnt_b;
    logic       terr_b;

    wb_arbiter_2m #(.TO_W(8), .TIMEOUT(8'd4)) dut_a (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .m0       (bus_a0),
        .m1       (bus_a1),
        .s        (bus_as),
        .gnt_o    (gnt_a),
        .to_err_o (terr_a)
    );

    wb_arbiter_2m #(.TO_W(8), .TIMEOUT(8'd0)) dut_b (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .m0       (bus_b0),
        .m1       (bus_b1),
        .s        (bus_bs),
        .gnt_o    (gnt_b),
        .to_err_o (terr_b)
    );

    int assertCount = 0;
    int failCount   = 0;

    model_t modelA = '{owner: 0, last: 1, waited: 0};
    model_t modelB = '{owner: 0, last: 1, waited: 0};
    logic   modelValid = 1'b0;

    m_in_t inA0, inA1, inB0, inB1;
    assign inA0 = {bus_a0.cyc, bus_a0.stb, bus_a0.we, bus_a0.sel, bus_a0.adr, bus_a0.dat_w};
    assign inA1 = {bus_a1.cyc, bus_a1.stb, bus_a1.we, bus_a1.sel, bus_a1.adr, bus_a1.dat_w};
    assign inB0 = {bus_b0.cyc, bus_b0.stb, bus_b0.we, bus_b0.sel, bus_b0.adr, bus_b0.dat_w};
    assign inB1 = {bus_b1.cyc, bus_b1.stb, bus_b1.we, bus_b1.sel, bus_b1.adr, bus_b1.dat_w};

    logic [77:0] obsA, obsB;
    assign obsA = {gnt_a, terr_a, bus_as.cyc, bus_as.stb, bus_as.we, bus_as.adr, bus_as.sel,
                   bus_as.dat_w, bus_a0.ack, bus_a0.dat_r, bus_a1.ack, bus_a1.dat_r};
    assign obsB = {gnt_b, terr_b, bus_bs.cyc, bus_bs.stb, bus_bs.we, bus_bs.adr, bus_bs.sel,
                   bus_bs.dat_w, bus_b0.ack, bus_b0.dat_r, bus_b1.ack, bus_b1.dat_r};

    // The watchdog fires once the owner has stalled a strobe for `timeout` cycles.
    function automatic logic watchdogFires(input model_t m, input int timeout,
                                           input m_in_t q0, input m_in_t q1, input logic sAck);
        m_in_t own;
        own = (m.owner == 1) ? q0 : (m.owner == 2) ? q1 : '0;
        return own.cyc && own.stb && (timeout != 0) && (m.waited == timeout) && !sAck;
    endfunction

    // Expected outputs for the current cycle, in the same order as obsA/obsB.
    function automatic logic [77:0] predict(input model_t m, input int timeout,
                                            input m_in_t q0, input m_in_t q1,
                                            input logic sAck, input logic [15:0] sDat);
        m_in_t       own;
        logic [1:0]  gnt;
        logic        terr;
        logic        ack;
        logic [15:0] rdat;
        own = '0;
        gnt = 2'b00;
        if (m.owner == 1) begin
            own = q0;
            gnt = 2'b01;
        end else if (m.owner == 2) begin
            own = q1;
            gnt = 2'b10;
        end
        terr = watchdogFires(m, timeout, q0, q1, sAck);
        ack  = (sAck || terr) && own.cyc && own.stb;
        rdat = terr ? 16'hFFFF : sDat;
        return {gnt, terr, own.cyc, (own.cyc & own.stb & ~terr), own.we, own.adr, own.sel, own.dat,
                (m.owner == 1) ? ack : 1'b0, (m.owner == 1) ? rdat : 16'h0000,
                (m.owner == 2) ? ack : 1'b0, (m.owner == 2) ? rdat : 16'h0000};
    endfunction

    // Ownership and stall time after a clock edge.
    function automatic model_t advance(input model_t m, input int timeout,
                                       input m_in_t q0, input m_in_t q1,
                                       input logic sAck, input logic rst);
        model_t n;
        int     nextOwner;
        logic   stalled;
        if (rst) begin
            n = '{owner: 0, last: 1, waited: 0};
            return n;
        end
        if (m.owner == 1 && q0.cyc)      nextOwner = 1;
        else if (m.owner == 2 && q1.cyc) nextOwner = 2;
        else if (q0.cyc && q1.cyc)       nextOwner = (m.owner == 1) ? 2 : (m.owner == 2) ? 1 : (m.last == 1 ? 1 : 2);
        else if (q0.cyc)                 nextOwner = 1;
        else if (q1.cyc)                 nextOwner = 2;
        else                             nextOwner = 0;
        n = m;
        n.owner = nextOwner;
        stalled = (m.owner == 1 && q0.cyc && q0.stb) || (m.owner == 2 && q1.cyc && q1.stb);
        if (nextOwner != m.owner) begin
            n.waited = 0;
            if (nextOwner != 0) n.last = nextOwner - 1;
        end else if (stalled && !sAck && !watchdogFires(m, timeout, q0, q1, sAck)) begin
            n.waited = (m.waited < timeout) ? m.waited + 1 : timeout;
        end else begin
            n.waited = 0;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [77:0] actual, input logic [77:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    // Model state follows the DUTs on every rising edge.
    always @(posedge wb_clk_i) begin
        if (wb_rst_i) modelValid = 1'b1;
        modelA = advance(modelA, 4, inA0, inA1, bus_as.ack, wb_rst_i);
        modelB = advance(modelB, 0, inB0, inB1, bus_bs.ack, wb_rst_i);
    end

    // Every cycle after the first reset, both DUTs must match the model.
    always @(negedge wb_clk_i) begin
        if (modelValid) begin
            checkOutput("cycle model A", obsA, predict(modelA, 4, inA0, inA1, bus_as.ack, bus_as.dat_r));
            checkOutput("cycle model B", obsB, predict(modelB, 0, inB0, inB1, bus_bs.ack, bus_bs.dat_r));
        end
    end

    task automatic nextCycle();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic settle();
        @(negedge wb_clk_i);
    endtask

    // Drive one master port: 0/1 = dut_a m0/m1, 2/3 = dut_b m0/m1.
    task automatic applyStimulus(input int which, input logic cyc, input logic stb, input logic we,
                                 input logic [19:0] adr, input logic [15:0] dat);
        case (which)
            0: begin bus_a0.cyc = cyc; bus_a0.stb = stb; bus_a0.we = we; bus_a0.adr = adr; bus_a0.dat_w = dat; bus_a0.sel = 2'b11; end
            1: begin bus_a1.cyc = cyc; bus_a1.stb = stb; bus_a1.we = we; bus_a1.adr = adr; bus_a1.dat_w = dat; bus_a1.sel = 2'b01; end
            2: begin bus_b0.cyc = cyc; bus_b0.stb = stb; bus_b0.we = we; bus_b0.adr = adr; bus_b0.dat_w = dat; bus_b0.sel = 2'b11; end
            default: begin bus_b1.cyc = cyc; bus_b1.stb = stb; bus_b1.we = we; bus_b1.adr = adr; bus_b1.dat_w = dat; bus_b1.sel = 2'b10; end
        endcase
    endtask

    task automatic driveSlave(input int which, input logic ack, input logic [15:0] dat);
        if (which == 0) begin
            bus_as.ack   = ack;
            bus_as.dat_r = dat;
        end else begin
            bus_bs.ack   = ack;
            bus_bs.dat_r = dat;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global time limit: got no finish, expected finish before 100000");
        $fatal(1, "[TB] time limit expired");
    end

    initial begin
        logic seenEarly;
        wb_rst_i = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        driveSlave(0, 1'b0, 16'h0);
        driveSlave(1, 1'b0, 16'h0);
        nextCycle();
        nextCycle();
        wb_rst_i = 1'b0;
        settle();
        checkOutput("reset gnt", gnt_a, 2'b00);
        checkOutput("reset s_cyc", bus_as.cyc, 1'b0);
        checkOutput("reset to_err", terr_a, 1'b0);

        $display("[TB] m0 read alone");
        nextCycle(); applyStimulus(0, 1'b1, 1'b1, 1'b0, 20'h00400, 16'h0000);
        settle();    checkOutput("arb latency gnt", gnt_a, 2'b00);
        nextCycle(); settle();
        checkOutput("m0 granted", gnt_a, 2'b01);
        checkOutput("m0 adr out", bus_as.adr, 20'h00400);
        nextCycle(); settle();
        nextCycle(); driveSlave(0, 1'b1, 16'hBEEF);
        settle();
        checkOutput("m0 read ack", bus_a0.ack, 1'b1);
        checkOutput("m0 read data", bus_a0.dat_r, 16'hBEEF);
        checkOutput("m1 no ack", bus_a1.ack, 1'b0);
        nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        nextCycle(); settle();
        checkOutput("idle after read", gnt_a, 2'b00);

        $display("[TB] simultaneous requests");
        nextCycle(); wb_rst_i = 1'b1;
        nextCycle(); wb_rst_i = 1'b0;
        nextCycle();
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 20'h00010, 16'h1111);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 20'h00020, 16'h0000);
        nextCycle(); driveSlave(0, 1'b1, 16'h0000);
        settle();    checkOutput("tie goes to m0", gnt_a, 2'b01);
        nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        nextCycle(); driveSlave(0, 1'b1, 16'h2222);
        settle();
        checkOutput("handover no idle", gnt_a, 2'b10);
        checkOutput("m1 read data", bus_a1.dat_r, 16'h2222);
        nextCycle(); applyStimulus(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        for (int r = 0; r < 4; r++) begin
            nextCycle();
            applyStimulus(0, 1'b1, 1'b1, 1'b0, 20'h00100, 16'h0);
            applyStimulus(1, 1'b1, 1'b1, 1'b0, 20'h00200, 16'h0);
            settle(); checkOutput("round idle", gnt_a, 2'b00);
            nextCycle(); driveSlave(0, 1'b1, 16'h00A0 + 16'(r));
            settle(); checkOutput("round winner", gnt_a, (r % 2 == 0) ? 2'b01 : 2'b10);
            nextCycle();
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
            applyStimulus(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
            driveSlave(0, 1'b0, 16'h0);
        end
        nextCycle();

        $display("[TB] m1 locked burst");
        nextCycle(); applyStimulus(1, 1'b1, 1'b1, 1'b1, 20'h00030, 16'h3333);
        nextCycle(); applyStimulus(0, 1'b1, 1'b1, 1'b0, 20'h00040, 16'h0); driveSlave(0, 1'b1, 16'h3000);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin
                nextCycle(); driveSlave(0, 1'b1, 16'h3000 + 16'(k));
            end
            settle();
            checkOutput("burst gnt held", gnt_a, 2'b10);
            checkOutput("burst m1 ack", bus_a1.ack, 1'b1);
        end
        nextCycle(); applyStimulus(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        settle();    checkOutput("m0 waits for m1 cyc", gnt_a, 2'b10);
        nextCycle(); driveSlave(0, 1'b1, 16'h4000);
        settle();
        checkOutput("m0 after burst", gnt_a, 2'b01);
        checkOutput("m0 data after burst", bus_a0.dat_r, 16'h4000);
        nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        nextCycle();

        $display("[TB] watchdog");
        nextCycle(); applyStimulus(0, 1'b1, 1'b1, 1'b0, 20'h00050, 16'h0); driveSlave(0, 1'b0, 16'h5555);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                nextCycle(); settle();
                checkOutput("no early timeout", terr_a, 1'b0);
            end
            nextCycle(); settle();
            checkOutput("timeout pulse", terr_a, 1'b1);
            checkOutput("timeout ack", bus_a0.ack, 1'b1);
            checkOutput("timeout data", bus_a0.dat_r, 16'hFFFF);
            checkOutput("timeout stb", bus_as.stb, 1'b0);
        end
        nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        nextCycle();
        nextCycle(); applyStimulus(0, 1'b1, 1'b1, 1'b0, 20'h00060, 16'h0);
        for (int k = 0; k < 4; k++) nextCycle();
        nextCycle(); driveSlave(0, 1'b1, 16'h1234);
        settle();
        checkOutput("late ack no error", terr_a, 1'b0);
        checkOutput("late ack data", bus_a0.dat_r, 16'h1234);
        nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        nextCycle();

        $display("[TB] reset during m1 wait");
        nextCycle(); applyStimulus(1, 1'b1, 1'b1, 1'b0, 20'h00070, 16'h0);
        nextCycle(); settle(); checkOutput("m1 in wait", gnt_a, 2'b10);
        nextCycle(); wb_rst_i = 1'b1;
        nextCycle(); wb_rst_i = 1'b0; applyStimulus(0, 1'b1, 1'b1, 1'b0, 20'h00080, 16'h0);
        settle();
        checkOutput("reset drops gnt", gnt_a, 2'b00);
        checkOutput("reset drops s_cyc", bus_as.cyc, 1'b0);
        checkOutput("reset no m1 ack", bus_a1.ack, 1'b0);
        nextCycle(); driveSlave(0, 1'b1, 16'h6666);
        settle();    checkOutput("m0 first after reset", gnt_a, 2'b01);
        nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        nextCycle(); driveSlave(0, 1'b1, 16'h7777);
        settle();    checkOutput("m1 after m0", gnt_a, 2'b10);
        nextCycle(); applyStimulus(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(0, 1'b0, 16'h0);
        nextCycle();

        $display("[TB] watchdog disabled, slow slave");
        nextCycle(); applyStimulus(2, 1'b1, 1'b1, 1'b0, 20'h00090, 16'h0);
        seenEarly = 1'b0;
        for (int k = 0; k < 300; k++) begin
            nextCycle(); settle();
            seenEarly = seenEarly | terr_b | bus_b0.ack;
        end
        checkOutput("no ack or error before 300", seenEarly, 1'b0);
        nextCycle(); driveSlave(1, 1'b1, 16'hCAFE);
        settle();
        checkOutput("slow ack delivered", bus_b0.ack, 1'b1);
        checkOutput("slow ack data", bus_b0.dat_r, 16'hCAFE);
        checkOutput("slow ack no error", terr_b, 1'b0);
        nextCycle(); applyStimulus(2, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0); driveSlave(1, 1'b0, 16'h0);
        nextCycle();
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
